alu_div4_seq: RTL and testbench
===============================

ALU_DIV4_SEQ -- requirements
Module: alu_div4_seq

Interface
REQ-001 Parameter DW, default 8, dividend and quotient width; matches the ALU product width.
REQ-002 Parameter VW, default 4, divisor and remainder width; matches the ALU operand width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 dividend  input  DW  numerator, unsigned; sampled with start.
REQ-007 divisor  input  VW  denominator, unsigned; sampled with start.
REQ-008 busy  output  1  high while in RUN or DONE.
REQ-009 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 dbz  output  1  divide-by-zero flag; valid with done, held until next accepted start.
REQ-011 quotient  output  DW  floor(dividend/divisor), unsigned.
REQ-012 remainder  output  VW  dividend mod divisor, unsigned.

Function
REQ-013 The block SHALL implement a restoring shift-subtract divider that resolves one quotient bit per clock, MSB first.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 and divisor!=0 at edge E0 SHALL capture both operands, clear the partial remainder (VW+1 bits), set the iteration counter to DW-1 and enter RUN.
REQ-016 Each RUN edge SHALL shift the next dividend bit into the partial remainder, subtract the divisor and record the quotient bit: 1 if the difference is non-negative (difference kept), otherwise 0 (remainder restored).
REQ-017 RUN SHALL last exactly DW edges (E1..E8 at defaults); the final iteration edge SHALL enter DONE.
REQ-018 quotient and remainder SHALL update at the E8 edge, so done is high in the cycle after E8; total latency is 8 cycles from the capture edge.
REQ-019 DONE SHALL last one cycle and then return to IDLE unconditionally; done SHALL never be high for two consecutive cycles.
REQ-020 IDLE with start=1 and divisor==0 at E0 SHALL go directly to DONE with dbz=1, quotient={DW{1'b1}} and remainder=dividend[VW-1:0]; done is high in the cycle after E0.
REQ-021 A start accepted with divisor!=0 SHALL clear dbz at E0.
REQ-022 start SHALL be ignored in RUN and DONE; input operand changes during RUN SHALL NOT affect the result.
REQ-023 quotient, remainder and dbz SHALL hold their last values from the done cycle until the next completion (no intermediate values exposed).
REQ-024 The earliest back-to-back start SHALL be the first IDLE cycle after DONE, i.e. 10 edges between accepted starts.
REQ-025 The intermediate subtraction SHALL use VW+1 bits so that no overflow occurs for any divisor up to 2^VW-1.
REQ-026 Result identity: quotient*divisor+remainder==dividend and remainder<divisor SHALL hold for every nonzero divisor.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE and set busy=0, done=0, dbz=0, quotient=0 and remainder=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the first start SHALL behave per REQ-015.
REQ-029 The block SHALL leave reset on the first rising edge after rst_n goes high and SHALL NOT accept start on that edge if it coincides with the release edge.

Verification
REQ-030 Divide 200/7 -> done exactly 8 cycles after the capture edge, quotient=28, remainder=4, dbz=0, busy high for 9 cycles.
REQ-031 Divide 50/0 -> done 1 cycle after capture, dbz=1, quotient=8'hFF, remainder=4'h2; next 50/5 -> dbz=0, quotient=10, remainder=0.
REQ-032 Boundary cases: 255/1 -> 255 rem 0; 0/15 -> 0 rem 0; 255/15 -> 17 rem 0; 14/15 -> 0 rem 14.
REQ-033 start held high continuously with 100/3 while operands are changed during RUN -> results 33 rem 1; each done is single-cycle, starts are accepted exactly every 10 edges.
REQ-034 rst_n pulsed low at RUN edge 4 of 99/9 -> outputs 0 immediately, no done; then 99/9 -> 11 rem 0.
REQ-035 Exhaustive sweep over all 4096 dividend/divisor pairs -> REQ-026 holds, and dbz=1 for exactly the 256 pairs with divisor=0.

Source files
------------

// File: rtl/alu_div4_seq.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock, MSB first.
// Results and the divide-by-zero flag are registered and held between completions.
//
// state  | meaning
// IDLE   | waiting for start; last results held
// RUN    | DW iterations, one quotient bit per edge
// DONE   | one-cycle done pulse, results valid
module alu_div4_seq #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          dbz,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          rdy_q, rdy_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   prem_q, prem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dbz_q, dbz_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;

    logic [VW:0]   shifted;
    logic [VW:0]   diff;
    logic          qbit;
    logic [VW:0]   prem_next;
    logic [DW-1:0] shreg_next;

    // shreg holds the unconsumed dividend bits on the left and the quotient bits on the right
    always_comb begin
        shifted    = {prem_q[VW-1:0], shreg_q[DW-1]};
        diff       = shifted - {1'b0, dvs_q};
        // a set top bit would mean the shifted value already exceeds any divisor
        qbit       = prem_q[VW] | ~diff[VW];
        prem_next  = qbit ? diff : shifted;
        shreg_next = {shreg_q[DW-2:0], qbit};
    end

    always_comb begin
        state_d     = state_q;
        rdy_d       = 1'b1;
        shreg_d     = shreg_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // rdy_q blocks a start that lands on the reset-release edge
                if (start && rdy_q) begin
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend[VW-1:0];
                    end else begin
                        state_d = S_RUN;
                        shreg_d = dividend;
                        dvs_d   = divisor;
                        prem_d  = '0;
                        cnt_d   = CW'(DW - 1);
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                shreg_d = shreg_next;
                prem_d  = prem_next;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    quotient_d  = shreg_next;
                    remainder_d = prem_next[VW-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdy_q       <= 1'b0;
            shreg_q     <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            shreg_q     <= shreg_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_alu_div4_seq.sv
// Directed bench for alu_div4_seq: hand-computed vectors, reset behaviour, held start and a full sweep.
module tb_alu_div4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic       dbz;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int         da, bn, dn;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         acc, prev_acc, zcount, nodone;

    alu_div4_seq #(.DW(8), .VW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge just after the capture edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample n is taken after edge n following the capture edge.
    task automatic collect(output int done_at, output int busy_n, output int done_n,
                           output logic [7:0] oq, output logic [3:0] orr, output logic oz);
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        oq      = '0;
        orr     = '0;
        oz      = 1'b0;
        for (int n = 0; n < 24; n++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = n;
                    oq      = quotient;
                    orr     = remainder;
                    oz      = dbz;
                end
            end
            if (done_at >= 0 && !done) break;
            @(negedge clk);
        end
    endtask

    task automatic run_div(input logic [7:0] a, input logic [3:0] b);
        launch(a, b);
        collect(da, bn, dn, q, r, z);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("reset_outputs", {busy, done, dbz, quotient, remainder}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run_div(8'd200, 4'd7);
        chk("d200_7_latency", da, 8);
        chk("d200_7_busy_cycles", bn, 9);
        chk("d200_7_done_width", dn, 1);
        chk("d200_7_q", q, 28);
        chk("d200_7_r", r, 4);
        chk("d200_7_dbz", z, 0);

        run_div(8'd50, 4'd0);
        chk("d50_0_latency", da, 0);
        chk("d50_0_done_width", dn, 1);
        chk("d50_0_q", q, 8'hFF);
        chk("d50_0_r", r, 4'h2);
        chk("d50_0_dbz", z, 1);
        @(negedge clk);
        @(negedge clk);
        chk("dbz_held_idle", dbz, 1);

        launch(8'd50, 4'd5);
        chk("dbz_clear_at_capture", dbz, 0);
        chk("q_held_during_run", quotient, 8'hFF);
        collect(da, bn, dn, q, r, z);
        chk("d50_5_q", q, 10);
        chk("d50_5_r", r, 0);
        chk("d50_5_dbz", z, 0);

        run_div(8'd255, 4'd1);
        chk("d255_1", {q, r}, {8'd255, 4'd0});
        run_div(8'd0, 4'd15);
        chk("d0_15", {q, r}, {8'd0, 4'd0});
        run_div(8'd255, 4'd15);
        chk("d255_15", {q, r}, {8'd17, 4'd0});
        run_div(8'd14, 4'd15);
        chk("d14_15", {q, r}, {8'd0, 4'd14});

        // start held high; operands disturbed during RUN and restored before the next accept
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
        prev_acc = -1;
        for (int k = 0; k < 3; k++) begin
            int w;
            w = 0;
            while (!busy && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("hold_busy", busy, 1);
            acc = cyc;
            if (k > 0) chk("hold_spacing", acc - prev_acc, 10);
            prev_acc = acc;
            dividend = 8'd77;
            divisor  = 4'd2;
            collect(da, bn, dn, q, r, z);
            chk("hold_q", q, 33);
            chk("hold_r", r, 1);
            chk("hold_done_width", dn, 1);
            dividend = 8'd100;
            divisor  = 4'd3;
        end
        start = 1'b0;

        // reset during RUN edge 4
        launch(8'd99, 4'd9);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {busy, done, dbz, quotient, remainder}, 0);
        nodone = 0;
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd9;
        repeat (3) begin
            @(negedge clk);
            if (done) nodone++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) nodone++;
        chk("midrun_no_done", nodone, 0);
        chk("release_edge_no_accept", busy, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("after_reset_accept", busy, 1);
        collect(da, bn, dn, q, r, z);
        chk("d99_9_latency", da, 8);
        chk("d99_9", {q, r}, {8'd11, 4'd0});

        zcount = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a[7:0], b[3:0]);
                if (z) zcount++;
                if (b == 0) begin
                    chk("sweep_dbz", {z, q, r}, {1'b1, 8'hFF, a[3:0]});
                end else begin
                    chk("sweep_div", {z, q, r}, {1'b0, 8'(a / b), 4'(a % b)});
                    chk("sweep_identity", ((int'(q) * b + int'(r)) == a) && (int'(r) < b), 1);
                end
            end
        end
        chk("sweep_dbz_count", zcount, 256);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
